// File: rtl/bram_dump.sv
// bram_dump: reads the backup SRAM out as a big-endian byte stream.
// Word reads are only issued in cycles the CPU leaves idle. A read that
// collides with a CPU access is abandoned and retried at the same address.
// A dirty flag records CPU writes so firmware can tell whether a captured
// image is stale.
//
// state | meaning
// IDLE  | waiting for start
// ARB   | waiting for a CPU-free cycle before reading
// READ  | driving ce/oe for RD_WAIT uncontended cycles
// HI    | presenting word[15:8]
// LO    | presenting word[7:0]
module bram_dump #(
    parameter int AW      = 19,
    parameter int RD_WAIT = 2
) (
    input  logic          clk,
    input  logic          map_rst_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    input  logic          cpu_ce,
    input  logic          cpu_we,
    input  logic [15:0]   mem_do,
    output logic [AW-1:0] mem_addr,
    output logic          mem_ce,
    output logic          mem_oe,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done,
    output logic          dirty
);

    localparam int WW = 4;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_READ, S_HI, S_LO} state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] addr;
    logic [AW:0]   rem;
    logic [15:0]   word;
    logic [WW-1:0] wait_cnt;
    logic          we_q;
    logic          done_q;
    logic          dirty_q;
    logic          accept;
    logic          read_last;
    logic          lo_fire;

    assign accept    = start && (state == S_IDLE);
    assign read_last = (state == S_READ) && !cpu_ce && (wait_cnt == WW'(RD_WAIT - 1));
    assign lo_fire   = (state == S_LO) && tx_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!map_rst_n) state <= S_IDLE;
        else            state <= state_nx;
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept && (len != '0)) state_nx = S_ARB;
            S_ARB:  if (!cpu_ce) state_nx = S_READ;
            S_READ: begin
                if (cpu_ce)         state_nx = S_ARB;
                else if (read_last) state_nx = S_HI;
            end
            S_HI:   if (tx_ready) state_nx = S_LO;
            S_LO:   if (tx_ready) state_nx = (rem == (AW+1)'(1)) ? S_IDLE : S_ARB;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state; ce/oe are gated by cpu_ce in the same cycle.
    always_comb begin
        mem_ce   = (state == S_READ) && !cpu_ce;
        mem_oe   = (state == S_READ) && !cpu_ce;
        tx_valid = (state == S_HI) || (state == S_LO);
        busy     = (state != S_IDLE);
        tx_data  = 8'h00;
        if (state == S_HI)      tx_data = word[15:8];
        else if (state == S_LO) tx_data = word[7:0];
    end

    // Address, word count, read timer, data latch, done pulse and dirty flag.
    // The wait counter restarts whenever a READ is interrupted or left.
    always_ff @(posedge clk) begin
        if (!map_rst_n) begin
            addr     <= '0;
            rem      <= '0;
            word     <= '0;
            wait_cnt <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            dirty_q  <= 1'b0;
        end else begin
            we_q   <= cpu_we;
            done_q <= (accept && (len == '0)) || (lo_fire && (rem == (AW+1)'(1)));
            // A CPU write edge outranks the clear from a coincident start.
            if (cpu_we && !we_q) dirty_q <= 1'b1;
            else if (accept)     dirty_q <= 1'b0;
            if (accept && (len != '0)) begin
                addr <= base;
                rem  <= len;
            end
            if ((state == S_READ) && !cpu_ce) begin
                wait_cnt <= wait_cnt + WW'(1);
                if (read_last) word <= mem_do;
            end else begin
                wait_cnt <= '0;
            end
            if (lo_fire) begin
                addr <= addr + AW'(1);
                rem  <= rem - (AW+1)'(1);
            end
        end
    end

    assign mem_addr = addr;
    assign done     = done_q;
    assign dirty    = dirty_q;

endmodule

// File: tb/tb_bram_dump.sv
// Bench for bram_dump: an SRAM image, a byte-level scoreboard of what the
// stream must carry, and directed scenarios with literal expectations.
module tb_bram_dump;

    localparam int AW      = 19;
    localparam int RD_WAIT = 2;

    logic          clk = 1'b0;
    logic          map_rst_n;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          cpu_ce;
    logic          cpu_we;
    logic [15:0]   mem_do;
    logic [AW-1:0] mem_addr;
    logic          mem_ce;
    logic          mem_oe;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          done;
    logic          dirty;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bram_dump #(.AW(AW), .RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .map_rst_n(map_rst_n), .start(start), .base(base), .len(len),
        .cpu_ce(cpu_ce), .cpu_we(cpu_we), .mem_do(mem_do), .mem_addr(mem_addr),
        .mem_ce(mem_ce), .mem_oe(mem_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .dirty(dirty)
    );

    // SRAM image: four pinned words, a simple pattern elsewhere.
    function automatic logic [15:0] mem_val(input logic [AW-1:0] a);
        case (a)
            19'h00010: return 16'h1234;
            19'h00011: return 16'hABCD;
            19'h00012: return 16'h0001;
            19'h00013: return 16'hFF00;
            default:   return a[15:0] ^ 16'hA5C3;
        endcase
    endfunction

    assign mem_do = mem_oe ? mem_val(mem_addr) : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard / model state
    logic [7:0]    m_q[$];
    logic [7:0]    rx[$];
    logic          m_active = 1'b0;
    logic          m_done   = 1'b0;
    logic          m_dirty  = 1'b0;
    logic          m_we     = 1'b0;
    logic          m_half   = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [15:0]   m_w;
    logic          m_acc;
    logic          m_rise;
    logic          chk_en   = 1'b0;
    int            oe_cnt   = 0;

    // Compare DUT against the model, then advance the model by one clock.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("dirty", dirty, m_dirty);
            chk("mem_addr", mem_addr, m_addr);
            if (cpu_ce) chk("mem_ce_gated", mem_ce, 0);
            if (m_q.size() == 0) chk("tx_valid_unexpected", tx_valid, 0);
            else if (tx_valid) begin
                chk("tx_data", tx_data, m_q[0]);
                chk("read_during_stream", mem_oe, 0);
            end
            if (mem_oe) oe_cnt++;
        end
        if (!map_rst_n) begin
            m_q.delete();
            m_active = 1'b0;
            m_done   = 1'b0;
            m_dirty  = 1'b0;
            m_we     = 1'b0;
            m_half   = 1'b0;
            m_addr   = '0;
        end else begin
            m_done = 1'b0;
            m_rise = cpu_we && !m_we;
            m_acc  = start && !m_active;
            if (tx_valid && tx_ready && m_q.size() != 0) begin
                rx.push_back(tx_data);
                void'(m_q.pop_front());
                if (m_half) m_addr = m_addr + 1'b1;
                m_half = !m_half;
                if (m_q.size() == 0) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
            if (m_acc) begin
                if (len == 0) m_done = 1'b1;
                else begin
                    m_active = 1'b1;
                    m_addr   = base;
                    m_half   = 1'b0;
                    for (int i = 0; i < int'(len); i++) begin
                        m_w = mem_val(AW'(base + AW'(i)));
                        m_q.push_back(m_w[15:8]);
                        m_q.push_back(m_w[7:0]);
                    end
                end
            end
            if (m_rise)     m_dirty = 1'b1;
            else if (m_acc) m_dirty = 1'b0;
            m_we = cpu_we;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present start for one clock; returns in cycle 1 of the dump.
    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
        start = 1'b1;
        base  = b;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done && n < n0 + 400) begin
            tick();
            n++;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_done: actual no done pulse, required pulse within 400 cycles");
        end
    endtask

    task automatic chk_bytes(input string name, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e[4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            if (rx.size() > i) chk(name, rx[i], e[i]);
            else chk(name, rx.size(), i + 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        int n;
        int fv;
        map_rst_n = 1'b0;
        start = 1'b0;
        base = '0;
        len = '0;
        cpu_ce = 1'b0;
        cpu_we = 1'b0;
        tx_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_mem_ce", mem_ce, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_dirty", dirty, 0);
        map_rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // Plain 4-word dump
        rx.delete();
        oe_cnt = 0;
        do_start(19'h00010, 4);
        n = 1;
        fv = 0;
        while (!done && n < 200) begin
            if (tx_valid && fv == 0) fv = n;
            tick();
            n++;
        end
        chk("t1_first_valid_cycle", fv, 2 + RD_WAIT);
        chk("t1_done_cycle", n, 1 + 4 * (RD_WAIT + 3));
        chk("t1_busy_at_done", busy, 0);
        chk("t1_rx_count", rx.size(), 8);
        chk_bytes("t1_bytes_lo", 8'h12, 8'h34, 8'hAB, 8'hCD);
        rx = rx[4:$];
        chk_bytes("t1_bytes_hi", 8'h00, 8'h01, 8'hFF, 8'h00);
        chk("t1_reads", oe_cnt, 4 * RD_WAIT);
        tick();

        // Contention in the second READ cycle of word 0
        rx.delete();
        oe_cnt = 0;
        do_start(19'h00010, 4);
        tick();
        tick();
        cpu_ce = 1'b1;
        #1;
        chk("t2_mem_ce_drop", mem_ce, 0);
        chk("t2_mem_oe_drop", mem_oe, 0);
        tick();
        tick();
        tick();
        cpu_ce = 1'b0;
        wait_done(6, n);
        chk("t2_done_cycle", n, 6 + 4 * (RD_WAIT + 3));
        chk("t2_rx_count", rx.size(), 8);
        chk_bytes("t2_bytes", 8'h12, 8'h34, 8'hAB, 8'hCD);
        chk("t2_reads", oe_cnt, 4 * RD_WAIT + 1);
        tick();

        // Backpressure in HI then LO
        rx.delete();
        oe_cnt = 0;
        tx_ready = 1'b0;
        do_start(19'h00010, 2);
        n = 1;
        while (!tx_valid && n < 50) begin
            tick();
            n++;
        end
        repeat (10) tick();
        chk("t3_hi_hold", tx_data, 8'h12);
        chk("t3_no_read_hi", oe_cnt, RD_WAIT);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        repeat (7) tick();
        chk("t3_lo_hold", tx_data, 8'h34);
        chk("t3_lo_valid", tx_valid, 1);
        chk("t3_no_read_lo", oe_cnt, RD_WAIT);
        tx_ready = 1'b1;
        wait_done(0, n);
        chk_bytes("t3_bytes", 8'h12, 8'h34, 8'hAB, 8'hCD);
        chk("t3_reads", oe_cnt, 2 * RD_WAIT);
        tick();

        // Address wrap, then a zero-length request
        rx.delete();
        do_start(19'h7FFFF, 2);
        wait_done(1, n);
        chk_bytes("t4_wrap_bytes", 8'h5A, 8'h3C, 8'hA5, 8'hC3);
        chk("t4_addr_after", mem_addr, 19'h00001);
        tick();
        do_start(19'h00010, 0);
        chk("t4_noop_done", done, 1);
        chk("t4_noop_busy", busy, 0);
        tick();
        chk("t4_noop_done_once", done, 0);
        chk("t4_noop_busy2", busy, 0);

        // Dirty tracking
        cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
        tick();
        chk("t5_dirty_idle", dirty, 1);
        do_start(19'h00010, 1);
        chk("t5_dirty_cleared", dirty, 0);
        tick();
        cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
        wait_done(3, n);
        chk("t5_dirty_at_done", dirty, 1);
        tick();
        cpu_we = 1'b1;
        do_start(19'h00010, 1);
        chk("t5_set_wins", dirty, 1);
        cpu_we = 1'b0;
        wait_done(1, n);
        tick();

        // Reset during HI of word 2
        rx.delete();
        do_start(19'h00010, 4);
        n = 1;
        while (!(rx.size() == 4 && tx_valid) && n < 100) begin
            tick();
            n++;
        end
        chk("t6_in_hi", tx_data, 8'h00);
        map_rst_n = 1'b0;
        tick();
        chk("t6_busy", busy, 0);
        chk("t6_tx_valid", tx_valid, 0);
        chk("t6_tx_data", tx_data, 0);
        chk("t6_mem_ce", mem_ce, 0);
        chk("t6_mem_oe", mem_oe, 0);
        chk("t6_mem_addr", mem_addr, 0);
        chk("t6_done", done, 0);
        map_rst_n = 1'b1;
        repeat (3) begin
            tick();
            chk("t6_no_done", done, 0);
        end
        rx.delete();
        do_start(19'h00020, 2);
        wait_done(1, n);
        chk_bytes("t6_new_dump", 8'hA5, 8'hE3, 8'hA5, 8'hE2);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
